pes_prbs_checker: RTL and testbench
===================================

# pes_prbs_checker

Serial PRBS checker that sits directly downstream of the 4-bit LFSR generator `pes_lfsr` and consumes its `q` bitstream. It self-synchronises to the x^4+x^3+1 sequence by predicting each bit from the previous four received bits: b[n] = b[n-3] ^ b[n-4], period 15. It declares lock after a run of correct predictions, then counts bit errors and drops lock on excessive error density. It is the built-in self-test companion to the generator.

## Interface
- `LOCK_COUNT`, default 8: consecutive correct predictions needed in HUNT to lock (≥1).
- `WINDOW`, default 16: length of the error-density window in compared bits (≥2).
- `UNLOCK_ERRS`, default 4: mismatches within one window that force loss of lock (≥1).
- `ERR_W`, default 16: width of the error counter.
- `clk`, input, 1: clock.
- `rst`, input, 1: asynchronous active-high reset.
- `bit_in`, input, 1: received serial bit.
- `bit_valid`, input, 1: `bit_in` is valid this cycle. Tie high when fed from `pes_lfsr` every cycle.
- `err_clr`, input, 1: synchronous clear of `err_count`.
- `locked`, output, 1: checker is in LOCKED.
- `err_pulse`, output, 1: one-cycle pulse for each mismatch while LOCKED.
- `err_count`, output, ERR_W: saturating count of mismatches while LOCKED.

## Operation
- History `hist[3:0]`, with `hist[0]` newest. On every valid bit, `hist <= {hist[2:0], bit_in}`. Invalid cycles change no state.
- Fill counter, 0..4: the first 4 valid bits after reset only fill `hist`; no comparison is made.
- Once the fill counter is 4, each valid bit is compared: `pred = hist[3] ^ hist[2]`, `mis = bit_in != pred`.
- **HUNT** state (reset state):
  - A correct compare increments `match_cnt`.
  - A mismatch clears `match_cnt`.
  - A compare while `hist == 4'b0000` counts as a mismatch. This prevents locking on the degenerate all-zero stream.
  - When `match_cnt` would reach `LOCK_COUNT`, go to LOCKED and clear `win_cnt`/`bad_cnt`.
  - No errors are counted in HUNT.
- **LOCKED** state:
  - On each compare, `win_cnt++` and `bad_cnt += mis`.
  - On a mismatch, `err_pulse` fires and `err_count` increments, saturating at 2^ERR_W-1.
  - If `bad_cnt + mis >= UNLOCK_ERRS`, go to HUNT and clear `match_cnt`. `hist` and the fill counter are kept.
  - Otherwise, if `win_cnt` reaches `WINDOW`, clear `win_cnt` and `bad_cnt`. The current bit belongs to the closing window.
- A single flipped bit produces 3 mismatches: at positions n, n+3 and n+4.
- `err_clr` is synchronous and clears `err_count`. If it coincides with a mismatch, the clear wins (count becomes 0), but `err_pulse` still asserts.
- `err_count` holds its value through unlock/relock. Only `rst` and `err_clr` clear it.

## Timing
- Reset values: `locked`=0, `err_pulse`=0, `err_count`=0. Internal state at reset: state HUNT, `hist`=0, all counters 0.
- All outputs are registered. They update on the edge that samples the causing bit.
- Lock latency from reset on a clean stream: `locked` rises after the edge sampling valid bit 4+LOCK_COUNT (bit 12 at defaults).
- `err_pulse` is high for exactly the one cycle after the edge sampling the mismatching bit.
- `locked` falls after the edge sampling the mismatch that reaches `UNLOCK_ERRS`. That bit still counts and pulses.
- Relock from HUNT with full history takes LOCK_COUNT clean bits.
- Asynchronous `rst` mid-operation immediately returns all outputs and state to their reset values.

## Structure
- Shared package `pes_prbs_pkg` holds:
  - `PRBS_ORDER` = 4.
  - Tap constants (3, 2).
  - State enum {HUNT, LOCKED}.
  - The generator and checker must both use these constants.
- One natural sub-module is `pes_prbs_predictor`: the history shift register, fill counter and `pred`/`mis` generation. The top level holds the FSM and counters.

## Test plan
- `pes_lfsr` seeded with 4'b1001 drives a clean stream, `bit_valid`=1 → `locked` rises after bit 12. `err_count` stays 0 for 200 bits.
- Locked, flip a single bit n (window not wrapping across n..n+4) → `err_pulse` at n, n+3 and n+4. `err_count`=3 and `locked` stays 1.
- Locked, flip adjacent bits n and n+1 → mismatches at n, n+1, n+3 and n+5. `locked` drops after n+5, then relocks 8 clean bits later. `err_count`=4.
- Constant 0 input for 100 bits → `locked` never asserts and `err_count`=0.
- `ERR_W`=4 with a repeated single-bit flip every 20 bits → `err_count` saturates at 15. Asserting `err_clr` on a mismatch cycle → `err_count`=0 and `err_pulse`=1.
- Assert `rst` while locked with `err_count`=5 → `locked`=0 and `err_count`=0 immediately. After release, relock takes 12 bits. Toggling `bit_valid` 50% stretches lock time to 12 valid bits.

Source files
------------

// File: rtl/pes_prbs_pkg.sv
// pes_prbs_pkg: constants and types shared by the x^4+x^3+1 PRBS generator
// and checker. The generator and the checker both derive their feedback
// from PRBS_ORDER and the two tap positions defined here.
package pes_prbs_pkg;

  // Polynomial order and tap positions within the history register
  // (bit 0 = newest bit): b[n] = b[n-4] ^ b[n-3].
  localparam int PRBS_ORDER = 4;
  localparam int TAP_HI     = 3;
  localparam int TAP_LO     = 2;

  // Checker synchronisation state.
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

  // Next bit of the sequence predicted from the last PRBS_ORDER bits.
  function automatic logic prbs_predict(input logic [PRBS_ORDER-1:0] hist);
    return hist[TAP_HI] ^ hist[TAP_LO];
  endfunction

endpackage

// File: rtl/pes_prbs_predictor.sv
// pes_prbs_predictor: history shift register, fill counter and bit
// prediction for the PRBS checker.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   i_bit_in       : received serial bit
//   i_bit_valid    : i_bit_in is valid this cycle
//   o_cmp          : a comparison is made this cycle (valid bit, history full)
//   o_mis          : received bit differs from the prediction
//   o_hist_zero    : history holds all zeros (degenerate stream)
module pes_prbs_predictor
  import pes_prbs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_bit_in,
  input  logic i_bit_valid,
  output logic o_cmp,
  output logic o_mis,
  output logic o_hist_zero
);

  logic [PRBS_ORDER-1:0] r_hist;
  logic [2:0]            r_fill;
  logic                  w_full;
  logic                  w_pred;

  // Shift each valid bit into the history and count the initial fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= 3'd0;
    end else if (i_bit_valid) begin
      r_hist <= {r_hist[PRBS_ORDER-2:0], i_bit_in};
      if (!w_full) begin
        r_fill <= r_fill + 3'd1;
      end
    end
  end

  // Prediction and compare qualifiers from the current history.
  always_comb begin
    w_full      = (r_fill == 3'(PRBS_ORDER));
    w_pred      = prbs_predict(r_hist);
    o_cmp       = i_bit_valid & w_full;
    o_mis       = (i_bit_in != w_pred);
    o_hist_zero = (r_hist == '0);
  end

endmodule

// File: rtl/pes_prbs_checker.sv
// pes_prbs_checker: self-synchronising checker for the x^4+x^3+1 PRBS
// stream produced by pes_lfsr. Locks after LOCK_COUNT consecutive correct
// predictions, then counts mismatches and drops lock when UNLOCK_ERRS
// mismatches fall within one WINDOW-bit window.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   i_bit_in       : received serial bit
//   i_bit_valid    : i_bit_in is valid this cycle
//   i_err_clr      : synchronous clear of o_err_count (wins over increment)
//   o_locked       : checker is in LOCKED
//   o_err_pulse    : one-cycle pulse per mismatch while LOCKED
//   o_err_count    : saturating mismatch count while LOCKED
module pes_prbs_checker
  import pes_prbs_pkg::*;
#(
  parameter int LOCK_COUNT  = 8,
  parameter int WINDOW      = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_bit_in,
  input  logic             i_bit_valid,
  input  logic             i_err_clr,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [ERR_W-1:0] o_err_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);
  localparam logic [MW-1:0] MATCH_LIM = MW'(LOCK_COUNT);
  localparam logic [WW-1:0] WIN_LIM   = WW'(WINDOW);
  localparam logic [BW-1:0] BAD_LIM   = BW'(UNLOCK_ERRS);

  prbs_state_t      r_state;
  logic [MW-1:0]    r_match_cnt;
  logic [WW-1:0]    r_win_cnt;
  logic [BW-1:0]    r_bad_cnt;
  logic             r_locked;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_count;

  logic             w_cmp;
  logic             w_mis;
  logic             w_hist_zero;
  logic [MW-1:0]    w_match_nxt;
  logic [WW-1:0]    w_win_nxt;
  logic [BW-1:0]    w_bad_nxt;
  logic             w_err_inc;

  pes_prbs_predictor u_predictor (
    .clk         (clk),
    .rst         (rst),
    .i_bit_in    (i_bit_in),
    .i_bit_valid (i_bit_valid),
    .o_cmp       (w_cmp),
    .o_mis       (w_mis),
    .o_hist_zero (w_hist_zero)
  );

  // Next-value arithmetic for the counters.
  always_comb begin
    w_match_nxt = r_match_cnt + MW'(1);
    w_win_nxt   = r_win_cnt + WW'(1);
    w_bad_nxt   = r_bad_cnt + BW'(w_mis);
    w_err_inc   = (r_state == LOCKED) & w_cmp & w_mis;
  end

  // Lock FSM, window counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= HUNT;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_bad_cnt   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      case (r_state)
        HUNT: begin
          if (w_cmp) begin
            // An all-zero history predicts zero forever; never lock on it.
            if (w_mis || w_hist_zero) begin
              r_match_cnt <= '0;
            end else if (w_match_nxt == MATCH_LIM) begin
              r_state     <= LOCKED;
              r_locked    <= 1'b1;
              r_match_cnt <= '0;
              r_win_cnt   <= '0;
              r_bad_cnt   <= '0;
            end else begin
              r_match_cnt <= w_match_nxt;
            end
          end
        end
        LOCKED: begin
          if (w_cmp) begin
            r_err_pulse <= w_mis;
            if (w_bad_nxt >= BAD_LIM) begin
              r_state     <= HUNT;
              r_locked    <= 1'b0;
              r_match_cnt <= '0;
            end else if (w_win_nxt == WIN_LIM) begin
              // The current bit closes the window.
              r_win_cnt <= '0;
              r_bad_cnt <= '0;
            end else begin
              r_win_cnt <= w_win_nxt;
              r_bad_cnt <= w_bad_nxt;
            end
          end
        end
        default: begin
          r_state     <= HUNT;
          r_locked    <= 1'b0;
          r_match_cnt <= '0;
        end
      endcase
      // Clear takes priority over a coincident mismatch.
      if (i_err_clr) begin
        r_err_count <= '0;
      end else if (w_err_inc && (r_err_count != {ERR_W{1'b1}})) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  assign o_locked    = r_locked;
  assign o_err_pulse = r_err_pulse;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_pes_prbs_checker.sv
// Scoreboard bench for pes_prbs_checker: an LFSR source with bit-flip
// injection drives two checkers (ERR_W=16 and ERR_W=4); a reference model
// pushes the expected outputs for every driven cycle.
module tb_pes_prbs_checker;
  import pes_prbs_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_bit_in;
  logic        i_bit_valid;
  logic        i_err_clr;
  logic        o_locked;
  logic        o_err_pulse;
  logic [15:0] o_err_count;
  logic        o_locked_s;
  logic        o_err_pulse_s;
  logic [3:0]  o_err_count_s;

  typedef struct {
    logic lk;
    logic pl;
    int   cnt;
  } exp_t;

  exp_t sb_q[$];
  logic m_bits[$];
  int   pulse_log[$];
  logic m_locked;
  int   m_run, m_errs, m_win_pos, m_win_bad;
  int   gv;
  int   n_tests;
  int   n_fail;
  logic [3:0] g;

  pes_prbs_checker dut (
    .clk         (clk),
    .rst         (rst),
    .i_bit_in    (i_bit_in),
    .i_bit_valid (i_bit_valid),
    .i_err_clr   (i_err_clr),
    .o_locked    (o_locked),
    .o_err_pulse (o_err_pulse),
    .o_err_count (o_err_count)
  );

  pes_prbs_checker #(.ERR_W(4)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .i_bit_in    (i_bit_in),
    .i_bit_valid (i_bit_valid),
    .i_err_clr   (i_err_clr),
    .o_locked    (o_locked_s),
    .o_err_pulse (o_err_pulse_s),
    .o_err_count (o_err_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (bit %0d, t=%0t)", tag, got, exp, gv, $time);
    end
  endtask

  // Reference LFSR source, b[n] = b[n-4] ^ b[n-3].
  task automatic gen_bit(output logic nb);
    nb = g[TAP_HI] ^ g[TAP_LO];
    g  = {g[2:0], nb};
  endtask

  // Reference checker behaviour; pushes the expected outputs for this cycle.
  task automatic model_step(input logic b, input logic v, input logic c);
    exp_t e;
    logic pred, mis, zero;
    int n;
    e.pl = 1'b0;
    if (v) begin
      n = m_bits.size();
      if (n >= 4) begin
        pred = m_bits[n-4] ^ m_bits[n-3];
        mis  = (b != pred);
        zero = ((m_bits[n-1] | m_bits[n-2] | m_bits[n-3] | m_bits[n-4]) == 1'b0);
        if (!m_locked) begin
          if (mis || zero) m_run = 0;
          else begin
            m_run++;
            if (m_run == 8) begin
              m_locked = 1'b1; m_run = 0; m_win_pos = 0; m_win_bad = 0;
            end
          end
        end else begin
          e.pl = mis;
          if (mis) begin m_errs++; m_win_bad++; end
          m_win_pos++;
          if (m_win_bad >= 4) begin
            m_locked = 1'b0; m_run = 0;
          end else if (m_win_pos == 16) begin
            m_win_pos = 0; m_win_bad = 0;
          end
        end
      end
      m_bits.push_back(b);
    end
    if (c) m_errs = 0;
    e.lk  = m_locked;
    e.cnt = m_errs;
    sb_q.push_back(e);
  endtask

  // Drive one cycle, then pop and compare the expectation after the edge.
  task automatic drive(input logic b, input logic v, input logic c);
    exp_t e;
    i_bit_in = b; i_bit_valid = v; i_err_clr = c;
    model_step(b, v, c);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    check_eq("locked", o_locked, e.lk);
    check_eq("err_pulse", o_err_pulse, e.pl);
    check_eq("err_count", o_err_count, (e.cnt > 65535) ? 65535 : e.cnt);
    check_eq("locked_w4", o_locked_s, e.lk);
    check_eq("err_count_w4", o_err_count_s, (e.cnt > 15) ? 15 : e.cnt);
    if (o_err_pulse) pulse_log.push_back(gv);
    i_err_clr = 1'b0;
  endtask

  // Valid bits up to index 'upto', flipping fa/fb and every 'every'-th bit.
  task automatic run_bits(input int upto, input int fa, input int fb, input int every, input int clr_at);
    logic b;
    while (gv < upto) begin
      gv++;
      gen_bit(b);
      if (gv == fa || gv == fb || (every > 0 && (gv % every) == 0)) b = ~b;
      drive(b, 1'b1, gv == clr_at);
    end
  endtask

  task automatic apply_reset();
    i_bit_valid = 1'b0; i_err_clr = 1'b0;
    #2; rst = 1'b1; #1;
    check_eq("rst_locked", o_locked, 0);
    check_eq("rst_pulse", o_err_pulse, 0);
    check_eq("rst_count", o_err_count, 0);
    check_eq("rst_count_w4", o_err_count_s, 0);
    m_bits.delete(); m_locked = 1'b0; m_run = 0; m_errs = 0;
    m_win_pos = 0; m_win_bad = 0; gv = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic b;
    n_tests = 0; n_fail = 0; gv = 0;
    g = 4'b1001;
    m_locked = 1'b0; m_run = 0; m_errs = 0; m_win_pos = 0; m_win_bad = 0;
    rst = 1'b1; i_bit_in = 1'b0; i_bit_valid = 1'b0; i_err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_locked", o_locked, 0);
    check_eq("reset_pulse", o_err_pulse, 0);
    check_eq("reset_count", o_err_count, 0);
    rst = 1'b0;

    // Clean stream: lock after bit 12, no errors over 200 bits.
    run_bits(11, -1, -1, 0, -1);
    check_eq("lock_pre_12", o_locked, 0);
    run_bits(12, -1, -1, 0, -1);
    check_eq("lock_at_12", o_locked, 1);
    run_bits(200, -1, -1, 0, -1);
    check_eq("clean_200_count", o_err_count, 0);

    // Single flip at 207 (window 205..220): pulses at 207, 210, 211.
    pulse_log.delete();
    run_bits(212, 207, -1, 0, -1);
    check_eq("single_npulse", pulse_log.size(), 3);
    if (pulse_log.size() == 3) begin
      check_eq("single_p0", pulse_log[0], 207);
      check_eq("single_p1", pulse_log[1], 210);
      check_eq("single_p2", pulse_log[2], 211);
    end
    check_eq("single_count", o_err_count, 3);
    check_eq("single_locked", o_locked, 1);

    // Adjacent flips 223/224 after a clear at 222: unlock after 228.
    run_bits(227, 223, 224, 0, 222);
    check_eq("adj_still_locked", o_locked, 1);
    run_bits(228, -1, -1, 0, -1);
    check_eq("adj_unlock", o_locked, 0);
    check_eq("adj_count", o_err_count, 4);
    run_bits(235, -1, -1, 0, -1);
    check_eq("relock_pre", o_locked, 0);
    run_bits(236, -1, -1, 0, -1);
    check_eq("relock", o_locked, 1);

    // Reach err_count=5 while locked, then asynchronous reset.
    run_bits(240, 240, -1, 0, -1);
    check_eq("pre_rst_count", o_err_count, 5);
    apply_reset();
    run_bits(11, -1, -1, 0, -1);
    check_eq("rst_relock_pre", o_locked, 0);
    run_bits(12, -1, -1, 0, -1);
    check_eq("rst_relock", o_locked, 1);

    // Flip every 20 bits: the 4-bit counter saturates at 15.
    run_bits(150, -1, -1, 20, -1);
    check_eq("sat_count_w4", o_err_count_s, 15);
    check_eq("sat_count_w16", o_err_count, 21);
    check_eq("sat_locked", o_locked, 1);

    // Clear coinciding with a mismatch: count 0, pulse still fires.
    run_bits(165, 165, -1, 0, 165);
    check_eq("clr_mis_pulse", o_err_pulse, 1);
    check_eq("clr_mis_count", o_err_count, 0);
    check_eq("clr_mis_count_w4", o_err_count_s, 0);
    run_bits(170, -1, -1, 0, -1);

    // 50% bit_valid: lock still takes 12 valid bits.
    apply_reset();
    while (gv < 12) begin
      drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      gv++;
      gen_bit(b);
      drive(b, 1'b1, 1'b0);
      if (gv == 11) check_eq("toggle_pre", o_locked, 0);
    end
    check_eq("toggle_lock", o_locked, 1);

    // All-zero stream never locks.
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      gv++;
      drive(1'b0, 1'b1, 1'b0);
    end
    check_eq("zero_locked", o_locked, 0);
    check_eq("zero_count", o_err_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
